branch_target_predictor: RTL and testbench
==========================================

// Module: branch_target_predictor
// PURPOSE
//  Produces the branch-prediction inputs consumed by the PC select logic. Direct-mapped BTB with
//  2-bit saturating counters, looked up combinationally with the IF PC. Prediction metadata is
//  carried IF->ID->EX; when EX resolves the branch, the block updates the table and reports
//  Br_Result. Sits between the fetch PC register and the EX branch comparator.
// PARAMETERS
//  ENTRIES   16  BTB entries, power of 2; index = PC[IDX_W+1:2], IDX_W = log2(ENTRIES)
//  XLEN      32  PC/target width; tag = PC[XLEN-1:IDX_W+2]
// PORTS
//  clk              in   1     rising-edge clock
//  rst              in   1     synchronous, active-high reset
//  PC_F             in   XLEN  PC of instruction in IF
//  Stall            in   1     hold IF/ID metadata, bubble into EX
//  Flush            in   1     squash ID and EX metadata (mispredict redirect)
//  Ex_Is_Branch     in   1     instruction in EX is a conditional branch
//  Ex_Taken         in   1     branch outcome resolved in EX
//  Ex_Target        in   XLEN  computed target (PC_ALU) in EX
//  Br_Dectected     out  1     IF PC hits a valid BTB entry (combinational)
//  Br_PredictedBit  out  1     counter MSB of hit entry; 0 on miss
//  PC_Predicted     out  XLEN  stored target of hit entry; 0 on miss
//  Br_Dectected_Ex  out  1     EX instruction was predicted (hit) at fetch
//  Br_Result        out  2     EX resolution code, see below
// BEHAVIOUR
//  - Reset (rst=1 at edge): all valid bits 0, counters 2'b01, ID/EX metadata cleared.
//    Hence Br_Dectected=0, Br_PredictedBit=0, PC_Predicted=0, Br_Dectected_Ex=0, Br_Result=2'b00.
//    Reset mid-update wins: the update is dropped.
//  - Lookup: 0-cycle, combinational. Hit = valid[idx] & tag[idx]==PC_F tag.
//  - Metadata pipe {valid, PC, hit, pred_bit, pred_target}: IF->ID->EX, 1 stage per cycle.
//    Priority: Flush > Stall > advance. Flush: ID and EX valid=0. Stall: ID holds, EX valid=0.
//    Br_Dectected_Ex = ex_valid & ex_hit.
//  - Br_Result (meaningful only when Br_Dectected_Ex=1, else 2'b00):
//    01 pred taken & taken & target==Ex_Target, or pred not-taken & not taken (correct)
//    10 pred taken, actually not taken           (PC_old+4)
//    11 pred taken, taken, target != Ex_Target   (PC_ALU)
//    00 pred not-taken, actually taken           (PC_ALU)
//  - Update at edge when ex_valid & Ex_Is_Branch (index/tag from EX-carried PC):
//    hit:  counter +1 if taken (sat 11), -1 if not (sat 00); target<=Ex_Target if taken.
//    miss & taken: allocate/replace: valid=1, tag, target=Ex_Target, counter=2'b10.
//    miss & not taken: no write.
//    The EX-stage hit is re-evaluated against current table (tag may have been replaced).
//  - Same-index lookup and update in one cycle: lookup returns pre-update contents.
//  - Update is not blocked by Stall or Flush in the same cycle (EX instruction is committed).
//  - Counter arithmetic 2-bit unsigned, saturating; never wraps.
// STRUCTURE
//  - Shared package: BR_RES_* encodings (00/01/10/11), CNT_WEAK_NT=2'b01, CNT_WEAK_T=2'b10.
//    The PC select logic uses the same constants.
//  - One sub-module: bp_sat_counter (2-bit saturating inc/dec, combinational next-state).
//  - Tables: flop arrays (valid, tag, target, cnt); no SRAM macro.
// TESTING
//  1 Reset, PC_F=0x100 -> Br_Dectected=0, Br_PredictedBit=0, PC_Predicted=0, Br_Result=00.
//  2 Branch at 0x100 taken to 0x200 (miss) -> Br_Dectected_Ex=0; refetch 0x100 -> hit,
//    PredictedBit=1, PC_Predicted=0x200; in EX, taken to 0x200 -> Br_Result=01, counter 11.
//  3 From counter 11, resolve not-taken twice -> Br_Result=10 then 10; third fetch
//    PredictedBit=0 (counter 01); resolve not-taken -> Br_Result=01, counter 00 (saturated).
//  4 Hit predicts 0x200, EX taken to 0x300 -> Br_Result=11; next fetch PC_Predicted=0x300.
//  5 0x100 and 0x140 alias (ENTRIES=16); allocate 0x100, then taken 0x140 -> 0x100 misses.
//    Also check same-cycle lookup/update on one index returns old entry.
//  6 Stall with hit in ID -> ID held, EX bubble (Br_Dectected_Ex=0); Flush+Stall together ->
//    both stages cleared; rst asserted during an update -> table stays cleared.

Source files
------------

// File: rtl/branch_target_predictor_pkg.sv
// Shared branch-prediction encodings used by the predictor and the PC select logic.
package branch_target_predictor_pkg;

  // Br_Result codes reported when EX resolves a predicted branch
  localparam logic [1:0] BR_RES_PNT_TAKEN  = 2'b00;  // predicted not-taken, taken -> PC_ALU
  localparam logic [1:0] BR_RES_CORRECT    = 2'b01;
  localparam logic [1:0] BR_RES_PT_NTAKEN  = 2'b10;  // predicted taken, not taken -> PC_old+4
  localparam logic [1:0] BR_RES_PT_BAD_TGT = 2'b11;  // predicted taken, wrong target -> PC_ALU

  localparam logic [1:0] CNT_STRONG_NT = 2'b00;
  localparam logic [1:0] CNT_WEAK_NT   = 2'b01;
  localparam logic [1:0] CNT_WEAK_T    = 2'b10;
  localparam logic [1:0] CNT_STRONG_T  = 2'b11;

endpackage

// File: rtl/branch_target_predictor_sat_counter.sv
// 2-bit saturating up/down counter next-state for BTB entries.
module bp_sat_counter
  import branch_target_predictor_pkg::*;
(
  input  logic [1:0] cnt,
  input  logic       inc,
  output logic [1:0] cnt_next_c
);

  always_comb begin
    cnt_next_c = cnt;
    if (inc) begin
      if (cnt != CNT_STRONG_T) cnt_next_c = cnt + 2'd1;
    end else begin
      if (cnt != CNT_STRONG_NT) cnt_next_c = cnt - 2'd1;
    end
  end

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with 2-bit counters; combinational IF lookup, metadata carried to EX
// where the branch is resolved, reported and written back.
module branch_target_predictor
  import branch_target_predictor_pkg::*;
#(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned XLEN    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] PC_F,
  input  logic            Stall,
  input  logic            Flush,
  input  logic            Ex_Is_Branch,
  input  logic            Ex_Taken,
  input  logic [XLEN-1:0] Ex_Target,
  output logic            Br_Dectected,
  output logic            Br_PredictedBit,
  output logic [XLEN-1:0] PC_Predicted,
  output logic            Br_Dectected_Ex,
  output logic [1:0]      Br_Result
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = XLEN - IDX_W - 2;
  localparam int unsigned WPC_W = XLEN - 2;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [XLEN-1:0]  target_q [ENTRIES];
  logic [1:0]       cnt_q    [ENTRIES];

  // PC carried as a word address; the byte-offset bits never reach the table
  logic [1:0] unused_pc_bits_c;
  assign unused_pc_bits_c = PC_F[1:0];

  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic             f_hit;

  assign f_idx = PC_F[IDX_W+1:2];
  assign f_tag = PC_F[XLEN-1:IDX_W+2];
  assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);

  assign Br_Dectected    = f_hit;
  assign Br_PredictedBit = f_hit & cnt_q[f_idx][1];
  assign PC_Predicted    = f_hit ? target_q[f_idx] : '0;

  logic             id_valid, id_hit, id_pred;
  logic [WPC_W-1:0] id_pc;
  logic [XLEN-1:0]  id_target;
  logic             ex_valid, ex_hit, ex_pred;
  logic [WPC_W-1:0] ex_pc;
  logic [XLEN-1:0]  ex_target;

  // Metadata pipe: Flush beats Stall beats advance
  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid  <= 1'b0;
      id_hit    <= 1'b0;
      id_pred   <= 1'b0;
      id_pc     <= '0;
      id_target <= '0;
      ex_valid  <= 1'b0;
      ex_hit    <= 1'b0;
      ex_pred   <= 1'b0;
      ex_pc     <= '0;
      ex_target <= '0;
    end else if (Flush) begin
      id_valid <= 1'b0;
      ex_valid <= 1'b0;
    end else if (Stall) begin
      ex_valid <= 1'b0;
    end else begin
      id_valid  <= 1'b1;
      id_hit    <= f_hit;
      id_pred   <= Br_PredictedBit;
      id_pc     <= PC_F[XLEN-1:2];
      id_target <= PC_Predicted;
      ex_valid  <= id_valid;
      ex_hit    <= id_hit;
      ex_pred   <= id_pred;
      ex_pc     <= id_pc;
      ex_target <= id_target;
    end
  end

  assign Br_Dectected_Ex = ex_valid & ex_hit;

  always_comb begin
    Br_Result = BR_RES_PNT_TAKEN;
    if (Br_Dectected_Ex) begin
      if (ex_pred) begin
        if (!Ex_Taken)                    Br_Result = BR_RES_PT_NTAKEN;
        else if (ex_target == Ex_Target)  Br_Result = BR_RES_CORRECT;
        else                              Br_Result = BR_RES_PT_BAD_TGT;
      end else begin
        Br_Result = Ex_Taken ? BR_RES_PNT_TAKEN : BR_RES_CORRECT;
      end
    end
  end

  // Update hit is re-evaluated: the entry may have been replaced since fetch
  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             u_hit;
  logic             do_update;
  logic [1:0]       cnt_next_c;

  assign u_idx     = ex_pc[IDX_W-1:0];
  assign u_tag     = ex_pc[WPC_W-1:IDX_W];
  assign u_hit     = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
  assign do_update = ex_valid & Ex_Is_Branch;

  bp_sat_counter u_sat_counter (
    .cnt        (cnt_q[u_idx]),
    .inc        (Ex_Taken),
    .cnt_next_c (cnt_next_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= CNT_WEAK_NT;
      end
    end else if (do_update) begin
      if (u_hit) begin
        cnt_q[u_idx] <= cnt_next_c;
        if (Ex_Taken) target_q[u_idx] <= Ex_Target;
      end else if (Ex_Taken) begin
        valid_q[u_idx]  <= 1'b1;
        tag_q[u_idx]    <= u_tag;
        target_q[u_idx] <= Ex_Target;
        cnt_q[u_idx]    <= CNT_WEAK_T;
      end
    end
  end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed vector bench for branch_target_predictor: per-cycle inputs and expected outputs.
module tb_branch_target_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PC_F;
  logic        Stall, Flush, Ex_Is_Branch, Ex_Taken;
  logic [31:0] Ex_Target;
  logic        Br_Dectected, Br_PredictedBit, Br_Dectected_Ex;
  logic [31:0] PC_Predicted;
  logic [1:0]  Br_Result;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  branch_target_predictor #(.ENTRIES(16), .XLEN(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .PC_F            (PC_F),
    .Stall           (Stall),
    .Flush           (Flush),
    .Ex_Is_Branch    (Ex_Is_Branch),
    .Ex_Taken        (Ex_Taken),
    .Ex_Target       (Ex_Target),
    .Br_Dectected    (Br_Dectected),
    .Br_PredictedBit (Br_PredictedBit),
    .PC_Predicted    (PC_Predicted),
    .Br_Dectected_Ex (Br_Dectected_Ex),
    .Br_Result       (Br_Result)
  );

  typedef struct {
    logic        rst;
    logic [31:0] pc;
    logic        stall, flush, br, tk;
    logic [31:0] tgt;
    logic        det, pb;
    logic [31:0] ppc;
    logic        dex;
    logic [1:0]  res;
  } vec_t;

  function automatic vec_t mk(logic r, logic [31:0] pc, logic st, logic fl, logic br,
                              logic tk, logic [31:0] tgt, logic det, logic pb,
                              logic [31:0] ppc, logic dex, logic [1:0] res);
    vec_t v;
    v.rst = r; v.pc = pc; v.stall = st; v.flush = fl; v.br = br; v.tk = tk; v.tgt = tgt;
    v.det = det; v.pb = pb; v.ppc = ppc; v.dex = dex; v.res = res;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one cycle, check outputs mid-cycle, then advance past the edge
  task automatic run_vec(input vec_t v, input string nm);
    rst = v.rst; PC_F = v.pc; Stall = v.stall; Flush = v.flush;
    Ex_Is_Branch = v.br; Ex_Taken = v.tk; Ex_Target = v.tgt;
    #2;
    chk({nm, ".det"},    32'(Br_Dectected),    32'(v.det));
    chk({nm, ".pbit"},   32'(Br_PredictedBit), 32'(v.pb));
    chk({nm, ".ppc"},    PC_Predicted,         v.ppc);
    chk({nm, ".det_ex"}, 32'(Br_Dectected_Ex), 32'(v.dex));
    chk({nm, ".result"}, 32'(Br_Result),       32'(v.res));
    @(posedge clk);
    #1;
  endtask

  vec_t vecs [33];
  vec_t seq  [13];

  initial begin
    // r   pc      st fl br tk tgt       det pb ppc     dex res
    vecs[0]  = mk(0, 32'h100, 0, 0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 2'b00);
    vecs[1]  = mk(0, 32'h004, 0, 0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 2'b00);
    vecs[2]  = mk(0, 32'h004, 0, 0, 1, 1, 32'h200, 0, 0, 32'h0,   0, 2'b00);
    vecs[3]  = mk(0, 32'h100, 0, 0, 0, 0, 32'h0,   1, 1, 32'h200, 0, 2'b00);
    vecs[4]  = mk(0, 32'h004, 0, 0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 2'b00);
    vecs[5]  = mk(0, 32'h004, 0, 0, 1, 1, 32'h200, 0, 0, 32'h0,   1, 2'b01);
    vecs[6]  = mk(0, 32'h100, 0, 0, 0, 0, 32'h0,   1, 1, 32'h200, 0, 2'b00);
    vecs[7]  = mk(0, 32'h100, 0, 0, 0, 0, 32'h0,   1, 1, 32'h200, 0, 2'b00);
    vecs[8]  = mk(0, 32'h004, 0, 0, 1, 0, 32'h0,   0, 0, 32'h0,   1, 2'b10);
    vecs[9]  = mk(0, 32'h004, 0, 0, 1, 0, 32'h0,   0, 0, 32'h0,   1, 2'b10);
    vecs[10] = mk(0, 32'h100, 0, 0, 0, 0, 32'h0,   1, 0, 32'h200, 0, 2'b00);
    vecs[11] = mk(0, 32'h004, 0, 0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 2'b00);
    vecs[12] = mk(0, 32'h004, 0, 0, 1, 0, 32'h0,   0, 0, 32'h0,   1, 2'b01);
    vecs[13] = mk(0, 32'h100, 0, 0, 0, 0, 32'h0,   1, 0, 32'h200, 0, 2'b00);
    vecs[14] = mk(0, 32'h004, 0, 0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 2'b00);
    vecs[15] = mk(0, 32'h004, 0, 0, 1, 0, 32'h0,   0, 0, 32'h0,   1, 2'b01);
    vecs[16] = mk(0, 32'h100, 0, 0, 0, 0, 32'h0,   1, 0, 32'h200, 0, 2'b00);
    vecs[17] = mk(0, 32'h004, 0, 0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 2'b00);
    vecs[18] = mk(0, 32'h004, 0, 0, 1, 1, 32'h200, 0, 0, 32'h0,   1, 2'b00);
    vecs[19] = mk(0, 32'h100, 0, 0, 0, 0, 32'h0,   1, 0, 32'h200, 0, 2'b00);
    vecs[20] = mk(0, 32'h004, 0, 0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 2'b00);
    vecs[21] = mk(0, 32'h004, 0, 0, 1, 1, 32'h200, 0, 0, 32'h0,   1, 2'b00);
    vecs[22] = mk(0, 32'h100, 0, 0, 0, 0, 32'h0,   1, 1, 32'h200, 0, 2'b00);
    vecs[23] = mk(0, 32'h004, 0, 0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 2'b00);
    vecs[24] = mk(0, 32'h004, 0, 0, 1, 1, 32'h300, 0, 0, 32'h0,   1, 2'b11);
    vecs[25] = mk(0, 32'h100, 0, 0, 0, 0, 32'h0,   1, 1, 32'h300, 0, 2'b00);
    vecs[26] = mk(0, 32'h140, 0, 0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 2'b00);
    vecs[27] = mk(0, 32'h004, 0, 0, 0, 0, 32'h0,   0, 0, 32'h0,   1, 2'b10);
    vecs[28] = mk(0, 32'h100, 0, 0, 1, 1, 32'h500, 1, 1, 32'h300, 0, 2'b00);
    vecs[29] = mk(0, 32'h100, 0, 0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 2'b00);
    vecs[30] = mk(0, 32'h140, 0, 0, 1, 0, 32'h0,   1, 1, 32'h500, 1, 2'b10);
    vecs[31] = mk(0, 32'h140, 0, 0, 0, 0, 32'h0,   1, 1, 32'h500, 0, 2'b00);
    vecs[32] = mk(0, 32'h004, 0, 0, 0, 1, 32'h500, 0, 0, 32'h0,   1, 2'b01);

    // Stall hold/bubble, Flush+Stall with committed update, reset during update
    seq[0]  = mk(0, 32'h140, 0, 0, 0, 0, 32'h0,   1, 1, 32'h500, 1, 2'b10);
    seq[1]  = mk(0, 32'h004, 1, 0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 2'b00);
    seq[2]  = mk(0, 32'h004, 0, 0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 2'b00);
    seq[3]  = mk(0, 32'h004, 0, 0, 0, 1, 32'h500, 0, 0, 32'h0,   1, 2'b01);
    seq[4]  = mk(0, 32'h140, 0, 0, 0, 0, 32'h0,   1, 1, 32'h500, 0, 2'b00);
    seq[5]  = mk(0, 32'h140, 0, 0, 0, 0, 32'h0,   1, 1, 32'h500, 0, 2'b00);
    seq[6]  = mk(0, 32'h004, 1, 1, 1, 1, 32'h600, 0, 0, 32'h0,   1, 2'b11);
    seq[7]  = mk(0, 32'h004, 0, 0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 2'b00);
    seq[8]  = mk(0, 32'h140, 0, 0, 0, 0, 32'h0,   1, 1, 32'h600, 0, 2'b00);
    seq[9]  = mk(1, 32'h004, 0, 0, 1, 1, 32'h700, 0, 0, 32'h0,   0, 2'b00);
    seq[10] = mk(0, 32'h004, 0, 0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 2'b00);
    seq[11] = mk(0, 32'h140, 0, 0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 2'b00);
    seq[12] = mk(0, 32'h004, 0, 0, 0, 0, 32'h0,   0, 0, 32'h0,   0, 2'b00);

    rst = 1'b1; PC_F = 32'h100; Stall = 1'b0; Flush = 1'b0;
    Ex_Is_Branch = 1'b0; Ex_Taken = 1'b0; Ex_Target = 32'h0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 33; i++) run_vec(vecs[i], $sformatf("vec%0d", i));
    for (int i = 0; i < 13; i++) run_vec(seq[i], $sformatf("seq%0d", i));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
